// File: rtl/ysyx_25020047_commit_ctrl_if.sv
// Bundle of the EXU offer, LSU request/response, register-file write and PC update signals.
// The master side is the commit controller; the slave side is the surrounding pipeline.
interface ysyx_25020047_commit_ctrl_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic [31:0] ex_dnpc;
  logic        ex_rf_we;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_wen;
  logic [31:0] pc_next;
  logic        commit;
  logic        err_timeout;

  modport master (
    input  ex_valid, ex_is_load, ex_is_store, ex_rd, ex_wdata, ex_dnpc, ex_rf_we,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output ex_ready, lsu_req_valid,
    output rf_wen, rf_waddr, rf_wdata, pc_wen, pc_next, commit, err_timeout
  );

  modport slave (
    output ex_valid, ex_is_load, ex_is_store, ex_rd, ex_wdata, ex_dnpc, ex_rf_we,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  ex_ready, lsu_req_valid,
    input  rf_wen, rf_waddr, rf_wdata, pc_wen, pc_next, commit, err_timeout
  );
endinterface

// File: rtl/ysyx_25020047_commit_ctrl.sv
// Single-issue commit controller: holds one executed instruction, runs its LSU access, then retires it.
// Define YSYX_25020047_COMMIT_TIMEOUT_EN to build the MEM_WAIT watchdog (err_timeout).
module ysyx_25020047_commit_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_25020047_commit_ctrl_if.master   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] COMMIT   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dnpc_q, dnpc_d;
  logic        rf_we_q, rf_we_d;
  logic        is_load_q, is_load_d;
  logic        in_commit;

`ifdef YSYX_25020047_COMMIT_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout_hit;

  // cnt_q holds the number of MEM_WAIT cycles already spent before the current one
  assign timeout_hit = (state_q == MEM_WAIT) && (cnt_q == TIMEOUT_LAST);
  assign cnt_d       = (state_q == MEM_WAIT) ? cnt_q + 8'd1 : 8'd0;
  assign err_d       = err_q | (timeout_hit & ~bus.lsu_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err_timeout = err_q;
`else
  logic [7:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 8'(TIMEOUT_CYCLES);
  assign bus.err_timeout    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    dnpc_d    = dnpc_q;
    rf_we_d   = rf_we_q;
    is_load_d = is_load_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          rd_d      = bus.ex_rd;
          wdata_d   = bus.ex_wdata;
          dnpc_d    = bus.ex_dnpc;
          rf_we_d   = bus.ex_rf_we;
          is_load_d = bus.ex_is_load;
          state_d   = (bus.ex_is_load || bus.ex_is_store) ? MEM_REQ : COMMIT;
        end
      end
      MEM_REQ: begin
        if (bus.lsu_req_ready) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // a store's response is only an acknowledgement; its wdata is kept
        if (bus.lsu_resp_valid) begin
          if (is_load_q) begin
            wdata_d = bus.lsu_resp_data;
          end
          state_d = COMMIT;
        end
`ifdef YSYX_25020047_COMMIT_TIMEOUT_EN
        else if (timeout_hit) begin
          rf_we_d = 1'b0;
          state_d = COMMIT;
        end
`endif
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= 5'd0;
      wdata_q   <= 32'd0;
      dnpc_q    <= 32'd0;
      rf_we_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      dnpc_q    <= dnpc_d;
      rf_we_q   <= rf_we_d;
      is_load_q <= is_load_d;
    end
  end

  assign in_commit         = (state_q == COMMIT);
  assign bus.ex_ready      = (state_q == IDLE);
  assign bus.lsu_req_valid = (state_q == MEM_REQ);
  assign bus.commit        = in_commit;
  assign bus.pc_wen        = in_commit;
  assign bus.pc_next       = dnpc_q;
  assign bus.rf_wen        = in_commit && rf_we_q && (rd_q != 5'd0);
  assign bus.rf_waddr      = rd_q;
  assign bus.rf_wdata      = wdata_q;

endmodule
